memctrl_bist: RTL and testbench
===============================

Name: memctrl_bist

Overview:
- Byte-wide synchronous memory controller around an internal single-port SRAM array of 2^ADDR_W x 8.
- Functional mode: an external host issues chip-enabled read and write cycles.
- BIST mode: an on-chip engine takes over the array, runs a selected memory test and reports the result on BIST_PASS.
- Sits between the SoC bus glue and the memory macro.

Parameters:
- ADDR_W, 16, address width; array depth is 2^ADDR_W bytes. The BIST sweeps the full depth.

Ports:
- CLK  in  1  rising-edge clock
- RSTN  in  1  synchronous reset, active-high (asserted when 1, sampled on CLK); name kept for codebase consistency
- ADDR  in  ADDR_W (16)  functional address
- CE  in  1  access enable, active-high
- CSB  in  1  chip select, active-low
- WEB  in  1  write enable, active-low
- OEB  in  1  output enable, active-low
- IDATA  in  8  write data
- BIST_EN  in  1  BIST request (level)
- BIST_MODE  in  3  algorithm select
- ODATA  out  8  read data, registered
- BIST_PASS  out  1  test completed with zero mismatches

Behaviour:
- Reset (RSTN=1 at edge):
  - ODATA=0, BIST_PASS=0, FSM=IDLE, BIST counters and fail flag cleared.
  - Array contents are not cleared.
- Functional access (BIST_EN=0, FSM=IDLE), valid when CE=1 and CSB=0:
  - WEB=0: mem[ADDR]<=IDATA at that edge; ODATA is unchanged. WEB=0 takes priority over OEB.
  - WEB=1, OEB=0: ODATA<=mem[ADDR] at that edge (1-cycle latency).
  - Read of an address written in the previous cycle returns the new data.
  - CE=0 or CSB=1: no array access; ODATA holds its value while OEB=0.
- OEB=1 at a clock edge (no write that cycle): ODATA<=0.
- FSM states: IDLE, RUN, CHECK, DONE.
- IDLE->RUN:
  - Transition happens when BIST_EN=1 and BIST_MODE is 001, 010 or 011. BIST_MODE is latched at this edge; later changes are ignored.
  - Reserved modes (000, 1xx) stay in IDLE with BIST_PASS=0.
- RUN:
  - Exactly one array op per cycle; functional inputs are ignored and ODATA=0.
  - A read issued in cycle k is compared in cycle k+1; any mismatch sets the sticky fail flag.
- After the last op, RUN->CHECK for one cycle to complete the final compare, then CHECK->DONE.
- DONE: BIST_PASS=~fail, held until BIST_EN=0 or reset. The test does not restart while BIST_EN stays 1.
- Latency: with K total ops, the first op executes in the cycle after the IDLE->RUN edge, and BIST_PASS is valid K+2 cycles after that edge.
- BIST_EN=0 in any state: next edge goes to IDLE with BIST_PASS=0 and fail cleared. This aborts a running test. Functional access resumes in the following cycle. Array contents after an abort are undefined.
- Data backgrounds: 0=8'h00, 1=8'hFF. N=2^ADDR_W. Up = addr 0..N-1, down = N-1..0.
- Mode 001, March C-, 10N ops:
  - up(w0); up(r0,w1); up(r1,w0); down(r0,w1); down(r1,w0); up(r0).
  - Elements with two ops do both ops per address before advancing.
- Mode 010, MATS+, 5N ops: up(w0); up(r0,w1); down(r1,w0).
- Mode 011, checkerboard, 4N ops:
  - up(w P); up(r P); up(w ~P); up(r ~P).
  - P=8'h55 for even addresses, 8'hAA for odd.
- Address counter wraps cleanly at element boundaries. No op is issued beyond N-1 or below 0.

Optional Feature:
- Macro: MEMCTRL_FAULT_INJECT_EN
- Defined: bit 0 of array word 0 reads as stuck-at-0 in both functional and BIST reads. Every BIST algorithm then finishes with BIST_PASS=0. Used to prove fail detection.
- Undefined: no fault; the array is ideal.

Test Plan:
- Reset, functional write/read, ADDR_W=16: reset; write 8'hA5 to 16'h1234; read 16'h1234 with OEB=0 -> ODATA=8'hA5 one cycle later. OEB=1 -> ODATA=0.
- Gating: write attempts with CSB=1, then with CE=0, to 16'h0010 -> a later read returns the prior contents. Back-to-back write then read of the same address -> new data.
- March C-, ADDR_W=4: RSTN=0, BIST_EN=1, BIST_MODE=001 -> BIST_PASS=0 through 161 cycles after start (160 ops + 1 CHECK cycle); BIST_PASS=1 at start+162 and held.
- MATS+ and checkerboard, ADDR_W=4: mode 010 -> pass at start+82; mode 011 -> pass at start+66. Reserved mode 101 -> FSM stays IDLE, BIST_PASS=0 indefinitely.
- Abort and changes mid-run: drop BIST_EN mid-March -> BIST_PASS=0 next cycle; a functional write then read of 8'h3C works. Changing BIST_MODE mid-run does not alter the op count.
- MEMCTRL_FAULT_INJECT_EN defined: each of the modes 001, 010 and 011 ends in DONE with BIST_PASS=0. Functional write 8'hFF to address 0 reads back 8'hFE.

Source files
------------

// File: rtl/memctrl_bist.sv
// Byte-wide single-port SRAM controller with an on-chip BIST engine.
// Functional host reads and writes run in IDLE. BIST_EN with a supported BIST_MODE starts
// March C- (001), MATS+ (010) or checkerboard (011) over the whole array.
// Optional build macro MEMCTRL_FAULT_INJECT_EN: bit 0 of word 0 reads back stuck-at-0.
module memctrl_bist #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              RSTN,       // synchronous, active-high despite the name
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              CE,
  input  logic              CSB,
  input  logic              WEB,
  input  logic              OEB,
  input  logic [7:0]        IDATA,
  input  logic              BIST_EN,
  input  logic [2:0]        BIST_MODE,
  output logic [7:0]        ODATA,
  output logic              BIST_PASS
);

  typedef enum logic [1:0] {StIdle, StRun, StCheck, StDone} state_e;

  // Data kinds: all-zero, all-one, checkerboard P, inverted checkerboard
  localparam logic [1:0] KZero = 2'd0;
  localparam logic [1:0] KOne  = 2'd1;
  localparam logic [1:0] KPat  = 2'd2;
  localparam logic [1:0] KPatN = 2'd3;

  // One march element: direction, op count, first op type and the data of both ops.
  // A second op, when present, is always a write.
  typedef struct packed {
    logic       last;
    logic       down;
    logic       two;
    logic       rd0;
    logic [1:0] k0;
    logic [1:0] k1;
  } elem_t;

  function automatic elem_t mk(logic last, logic down, logic two, logic rd0,
                               logic [1:0] k0, logic [1:0] k1);
    elem_t e;
    e.last = last;
    e.down = down;
    e.two  = two;
    e.rd0  = rd0;
    e.k0   = k0;
    e.k1   = k1;
    return e;
  endfunction

  function automatic elem_t elem_info(logic [1:0] mode, logic [2:0] idx);
    elem_t e;
    e = mk(1'b1, 1'b0, 1'b0, 1'b0, KZero, KZero);
    case (mode)
      2'd1: begin // March C-
        case (idx)
          3'd0:    e = mk(1'b0, 1'b0, 1'b0, 1'b0, KZero, KZero);
          3'd1:    e = mk(1'b0, 1'b0, 1'b1, 1'b1, KZero, KOne);
          3'd2:    e = mk(1'b0, 1'b0, 1'b1, 1'b1, KOne,  KZero);
          3'd3:    e = mk(1'b0, 1'b1, 1'b1, 1'b1, KZero, KOne);
          3'd4:    e = mk(1'b0, 1'b1, 1'b1, 1'b1, KOne,  KZero);
          default: e = mk(1'b1, 1'b0, 1'b0, 1'b1, KZero, KZero);
        endcase
      end
      2'd2: begin // MATS+
        case (idx)
          3'd0:    e = mk(1'b0, 1'b0, 1'b0, 1'b0, KZero, KZero);
          3'd1:    e = mk(1'b0, 1'b0, 1'b1, 1'b1, KZero, KOne);
          default: e = mk(1'b1, 1'b1, 1'b1, 1'b1, KOne,  KZero);
        endcase
      end
      2'd3: begin // checkerboard
        case (idx)
          3'd0:    e = mk(1'b0, 1'b0, 1'b0, 1'b0, KPat,  KZero);
          3'd1:    e = mk(1'b0, 1'b0, 1'b0, 1'b1, KPat,  KZero);
          3'd2:    e = mk(1'b0, 1'b0, 1'b0, 1'b0, KPatN, KZero);
          default: e = mk(1'b1, 1'b0, 1'b0, 1'b1, KPatN, KZero);
        endcase
      end
      default: e = mk(1'b1, 1'b0, 1'b0, 1'b0, KZero, KZero);
    endcase
    return e;
  endfunction

  function automatic logic [7:0] pattern(logic [1:0] kind, logic odd);
    case (kind)
      KZero:   return 8'h00;
      KOne:    return 8'hFF;
      KPat:    return odd ? 8'hAA : 8'h55;
      default: return odd ? 8'h55 : 8'hAA;
    endcase
  endfunction

  logic [7:0]        mem_q [2**ADDR_W];
  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [2:0]        elem_q, elem_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] baddr_q, baddr_d;
  logic              fail_q, fail_d;
  logic              pass_q, pass_d;
  logic              cmp_q, cmp_d;
  logic [7:0]        exp_q, exp_d;
  logic [7:0]        rd_q;
  logic [7:0]        odata_q, odata_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        rd_data;

  elem_t             cur, nxt;
  logic              cur_rd;
  logic [7:0]        cur_data;
  logic              addr_end;
  logic              host_valid;

  // Array read port, with the optional stuck-at fault on the read path
  always_comb begin
    rd_data = mem_q[mem_addr];
`ifdef MEMCTRL_FAULT_INJECT_EN
    if (mem_addr == '0) rd_data[0] = 1'b0;
`endif
  end

  // Next-state: functional access, BIST sequencing, compare and result
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    elem_d    = elem_q;
    op_d      = op_q;
    baddr_d   = baddr_q;
    fail_d    = fail_q;
    pass_d    = 1'b0;
    cmp_d     = 1'b0;
    exp_d     = exp_q;
    odata_d   = 8'h00;
    mem_we    = 1'b0;
    mem_addr  = ADDR;
    mem_wdata = IDATA;

    cur        = elem_info(mode_q, elem_q);
    nxt        = elem_info(mode_q, elem_q + 3'd1);
    cur_rd     = op_q ? 1'b0 : cur.rd0;
    cur_data   = pattern(op_q ? cur.k1 : cur.k0, baddr_q[0]);
    addr_end   = cur.down ? (baddr_q == '0) : (baddr_q == '1);
    host_valid = CE && !CSB;

    // A read issued last cycle is checked now
    if (cmp_q && (rd_q != exp_q)) fail_d = 1'b1;

    if (!BIST_EN) begin
      state_d = StIdle;
      fail_d  = 1'b0;
      if (state_q == StIdle) begin
        odata_d = odata_q;
        if (host_valid && !WEB) begin
          mem_we = 1'b1;
        end else if (OEB) begin
          odata_d = 8'h00;
        end else if (host_valid) begin
          odata_d = rd_data;
        end
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (BIST_MODE inside {3'b001, 3'b010, 3'b011}) begin
            state_d = StRun;
            mode_d  = BIST_MODE[1:0];
            elem_d  = 3'd0;
            op_d    = 1'b0;
            baddr_d = '0;
            fail_d  = 1'b0;
          end
        end
        StRun: begin
          mem_addr  = baddr_q;
          mem_wdata = cur_data;
          mem_we    = !cur_rd;
          cmp_d     = cur_rd;
          exp_d     = cur_data;
          if (cur.two && !op_q) begin
            op_d = 1'b1;
          end else begin
            op_d = 1'b0;
            if (addr_end) begin
              if (cur.last) begin
                state_d = StCheck;
              end else begin
                elem_d  = elem_q + 3'd1;
                baddr_d = nxt.down ? '1 : '0;
              end
            end else begin
              baddr_d = cur.down ? baddr_q - ADDR_W'(1) : baddr_q + ADDR_W'(1);
            end
          end
        end
        StCheck: state_d = StDone;
        StDone:  pass_d  = !fail_q;
        default: state_d = StIdle;
      endcase
    end
  end

  // Control and output registers
  always_ff @(posedge CLK) begin
    if (RSTN) begin
      state_q <= StIdle;
      mode_q  <= 2'd0;
      elem_q  <= 3'd0;
      op_q    <= 1'b0;
      baddr_q <= '0;
      fail_q  <= 1'b0;
      pass_q  <= 1'b0;
      cmp_q   <= 1'b0;
      exp_q   <= 8'h00;
      rd_q    <= 8'h00;
      odata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      elem_q  <= elem_d;
      op_q    <= op_d;
      baddr_q <= baddr_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
      cmp_q   <= cmp_d;
      exp_q   <= exp_d;
      rd_q    <= rd_data;
      odata_q <= odata_d;
    end
  end

  // Array write port; contents survive reset
  always_ff @(posedge CLK) begin
    if (mem_we && !RSTN) mem_q[mem_addr] <= mem_wdata;
  end

  assign ODATA     = odata_q;
  assign BIST_PASS = pass_q;

endmodule

// File: tb/tb_memctrl_bist.sv
// Self-checking bench for memctrl_bist: a 16-bit-address instance for host accesses and a
// 4-bit-address instance for BIST runs, both driven by the same stimulus.
module tb_memctrl_bist;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic        ce, csb, web, oeb;
  logic [7:0]  idata;
  logic        bist_en;
  logic [2:0]  bist_mode;
  logic [7:0]  odata16, odata4;
  logic        pass16, pass4;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  memctrl_bist #(.ADDR_W(16)) u_dut16 (
    .CLK(clk), .RSTN(rst), .ADDR(addr), .CE(ce), .CSB(csb), .WEB(web), .OEB(oeb),
    .IDATA(idata), .BIST_EN(bist_en), .BIST_MODE(bist_mode),
    .ODATA(odata16), .BIST_PASS(pass16)
  );

  memctrl_bist #(.ADDR_W(4)) u_dut4 (
    .CLK(clk), .RSTN(rst), .ADDR(addr[3:0]), .CE(ce), .CSB(csb), .WEB(web), .OEB(oeb),
    .IDATA(idata), .BIST_EN(bist_en), .BIST_MODE(bist_mode),
    .ODATA(odata4), .BIST_PASS(pass4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- host-side reference model ----------------
  logic [7:0] fmem [logic [15:0]];
  logic [7:0] fodata;

  function automatic logic [7:0] model_rd(input logic [15:0] a);
    logic [7:0] v;
    v = fmem[a];
`ifdef MEMCTRL_FAULT_INJECT_EN
    if (a == 16'h0000) v[0] = 1'b0;
`endif
    return v;
  endfunction

  task automatic func_cycle(input logic c, input logic cs, input logic we, input logic oe,
                            input logic [15:0] a, input logic [7:0] d, input string tag);
    ce = c; csb = cs; web = we; oeb = oe; addr = a; idata = d;
    tick();
    if (c && !cs && !we) fmem[a] = d;
    else if (oe)         fodata = 8'h00;
    else if (c && !cs)   fodata = model_rd(a);
    check_eq(tag, odata16, fodata);
  endtask

  // ---------------- BIST reference model (16-word array) ----------------
  logic [7:0] mm [16];
  int         m_ops;
  bit         m_fail;

  task automatic m_op(input bit rd, input logic [7:0] v, input int a);
    logic [7:0] r;
    m_ops++;
    if (rd) begin
      r = mm[a];
`ifdef MEMCTRL_FAULT_INJECT_EN
      if (a == 0) r[0] = 1'b0;
`endif
      if (r != v) m_fail = 1'b1;
    end else begin
      mm[a] = v;
    end
  endtask

  function automatic logic [7:0] ckb(input int a, input bit inv);
    logic [7:0] p;
    p = (a % 2 == 1) ? 8'hAA : 8'h55;
    return inv ? ~p : p;
  endfunction

  task automatic model_bist(input int mode, output int ops, output bit pass);
    m_ops = 0;
    m_fail = 1'b0;
    case (mode)
      1: begin
        for (int a = 0; a < 16; a++) m_op(0, 8'h00, a);
        for (int a = 0; a < 16; a++) begin m_op(1, 8'h00, a); m_op(0, 8'hFF, a); end
        for (int a = 0; a < 16; a++) begin m_op(1, 8'hFF, a); m_op(0, 8'h00, a); end
        for (int a = 15; a >= 0; a--) begin m_op(1, 8'h00, a); m_op(0, 8'hFF, a); end
        for (int a = 15; a >= 0; a--) begin m_op(1, 8'hFF, a); m_op(0, 8'h00, a); end
        for (int a = 0; a < 16; a++) m_op(1, 8'h00, a);
      end
      2: begin
        for (int a = 0; a < 16; a++) m_op(0, 8'h00, a);
        for (int a = 0; a < 16; a++) begin m_op(1, 8'h00, a); m_op(0, 8'hFF, a); end
        for (int a = 15; a >= 0; a--) begin m_op(1, 8'hFF, a); m_op(0, 8'h00, a); end
      end
      default: begin
        for (int a = 0; a < 16; a++) m_op(0, ckb(a, 0), a);
        for (int a = 0; a < 16; a++) m_op(1, ckb(a, 0), a);
        for (int a = 0; a < 16; a++) m_op(0, ckb(a, 1), a);
        for (int a = 0; a < 16; a++) m_op(1, ckb(a, 1), a);
      end
    endcase
    ops  = m_ops;
    pass = !m_fail;
  endtask

  // Start a test at the next edge, then track BIST_PASS every cycle against the model
  task automatic run_bist(input int mode, input int chg_at, input logic [2:0] chg_mode,
                          input string tag);
    int ops;
    bit exp_pass;
    model_bist(mode, ops, exp_pass);
    ce = 1'b0; csb = 1'b1; web = 1'b1; oeb = 1'b0;
    bist_en = 1'b1;
    bist_mode = 3'(mode);
    tick();
    for (int c = 1; c <= ops + 5; c++) begin
      if (c == chg_at) bist_mode = chg_mode;
      tick();
      check_eq($sformatf("%s_pass_c%0d", tag, c), pass4, (c >= ops + 2) ? exp_pass : 1'b0);
      if (c == 5) check_eq({tag, "_odata_run"}, odata4, 8'h00);
    end
    bist_en = 1'b0;
    bist_mode = 3'b000;
    tick();
    check_eq({tag, "_clear"}, pass4, 1'b0);
  endtask

  logic [15:0] pool [8];

  initial begin
    rst = 1'b1; bist_en = 1'b0; bist_mode = 3'b000;
    ce = 1'b0; csb = 1'b1; web = 1'b1; oeb = 1'b0; addr = 16'h0; idata = 8'h0;
    fodata = 8'h00;
    tick();
    tick();
    check_eq("rst_odata16", odata16, 8'h00);
    check_eq("rst_pass16", pass16, 1'b0);
    check_eq("rst_odata4", odata4, 8'h00);
    check_eq("rst_pass4", pass4, 1'b0);
    rst = 1'b0;

    // Directed host accesses
    func_cycle(1, 0, 0, 1, 16'h1234, 8'hA5, "wr_a5");
    func_cycle(1, 0, 1, 0, 16'h1234, 8'h00, "rd_a5");
    check_eq("rd_a5_const", odata16, 8'hA5);
    func_cycle(0, 1, 1, 0, 16'h1234, 8'h00, "hold_idle");
    check_eq("hold_idle_const", odata16, 8'hA5);
    func_cycle(0, 1, 1, 1, 16'h1234, 8'h00, "oeb_zero");
    check_eq("oeb_zero_const", odata16, 8'h00);

    func_cycle(1, 0, 0, 0, 16'h0010, 8'h11, "gate_init");
    func_cycle(1, 1, 0, 0, 16'h0010, 8'h99, "gate_csb");
    func_cycle(0, 0, 0, 0, 16'h0010, 8'h77, "gate_ce");
    func_cycle(1, 0, 1, 0, 16'h0010, 8'h00, "gate_rd");
    check_eq("gate_rd_const", odata16, 8'h11);
    func_cycle(1, 0, 0, 0, 16'h0010, 8'h5A, "b2b_wr");
    func_cycle(1, 0, 1, 0, 16'h0010, 8'h00, "b2b_rd");
    check_eq("b2b_rd_const", odata16, 8'h5A);

    func_cycle(1, 0, 0, 0, 16'h0000, 8'hFF, "a0_wr");
    func_cycle(1, 0, 1, 0, 16'h0000, 8'h00, "a0_rd");
`ifdef MEMCTRL_FAULT_INJECT_EN
    check_eq("a0_rd_const", odata16, 8'hFE);
`else
    check_eq("a0_rd_const", odata16, 8'hFF);
`endif

    // Randomized host traffic over a small preloaded address pool
    for (int i = 0; i < 8; i++) begin
      pool[i] = 16'($urandom_range(1, 16'hFFFF));
      func_cycle(1, 0, 0, 1, pool[i], 8'($urandom), "rnd_init");
    end
    for (int i = 0; i < 300; i++) begin
      func_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 1'($urandom),
                 $urandom_range(0, 3) == 0, pool[$urandom_range(0, 7)], 8'($urandom),
                 $sformatf("rnd_%0d", i));
    end

    // BIST runs on the small instance
    run_bist(1, 0, 3'b001, "march");
    run_bist(2, 0, 3'b010, "mats");
    run_bist(3, 0, 3'b011, "ckb");
    run_bist(1, 20, 3'b011, "march_chg");

    // Reserved mode never starts
    bist_en = 1'b1;
    bist_mode = 3'b101;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (c % 50 == 0) check_eq($sformatf("rsvd_pass_c%0d", c), pass4, 1'b0);
    end
    bist_en = 1'b0;
    tick();

    // Abort mid-March, then host access resumes
    bist_en = 1'b1;
    bist_mode = 3'b001;
    tick();
    repeat (50) tick();
    bist_en = 1'b0;
    tick();
    check_eq("abort_pass", pass4, 1'b0);
    check_eq("abort_odata", odata4, 8'h00);
    ce = 1'b1; csb = 1'b0; web = 1'b0; oeb = 1'b1; addr = 16'h0005; idata = 8'h3C;
    tick();
    web = 1'b1; oeb = 1'b0;
    tick();
    check_eq("abort_rd_3c", odata4, 8'h3C);
    ce = 1'b0; csb = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
